// File: rtl/control_if.sv
`default_nettype none
// ============================================================================
// Module      : control_if
// Description : Bundle of the signals that connect the game-flow controller
//               to the front panel and the datapath blocks.
//               master : front panel / datapath side (drives the inputs,
//                        observes the state and ready flag)
//               slave  : controller side
//               Signals:
//                 OK_IN     confirm/start button (level)
//                 QUE       player request for a new question (level)
//                 QUE_IN    question-generator valid (level)
//                 DEC       answer-submit button (level)
//                 SEL       quit selector, used in S_CLEAR
//                 JUDG_IN   judge result (00 pend, 01 ok, 10 wrong, 11 done)
//                 WRONG_IN  external penalty (level)
//                 HP_IN     remaining hit points
//                 READY_OUT high while the controller is in S_READY
//                 STATE     registered state code
// Revision    : 1.0 - initial release
// ============================================================================
interface control_if;
  logic       OK_IN;
  logic       QUE;
  logic       QUE_IN;
  logic       DEC;
  logic       SEL;
  logic [1:0] JUDG_IN;
  logic       WRONG_IN;
  logic [1:0] HP_IN;
  logic       READY_OUT;
  logic [3:0] STATE;

  modport master (
    output OK_IN, QUE, QUE_IN, DEC, SEL, JUDG_IN, WRONG_IN, HP_IN,
    input  READY_OUT, STATE
  );

  modport slave (
    input  OK_IN, QUE, QUE_IN, DEC, SEL, JUDG_IN, WRONG_IN, HP_IN,
    output READY_OUT, STATE
  );
endinterface
`default_nettype wire

// File: rtl/control.sv
`default_nettype none
// ============================================================================
// Module      : control
// Description : Game-flow controller for the factorization quiz. Sequences
//               start, question request, generation, answer entry, judging,
//               miss handling, clear and game over.
//               Ports:
//                 CLK  system clock, rising edge
//                 RST  synchronous active-low reset
//                 bus  control_if.slave (buttons, datapath status in;
//                      STATE and READY_OUT out)
// Revision    : 1.0 - initial release
// ============================================================================
module control (
  input  wire logic  CLK,
  input  wire logic  RST,
  control_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_READY = 4'd1,
    S_GEN   = 4'd2,
    S_SHOW  = 4'd3,
    S_JUDGE = 4'd4,
    S_MISS  = 4'd5,
    S_CLEAR = 4'd6,
    S_OVER  = 4'd7
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_ready;
  logic   r_ok_q;
  logic   r_dec_q;
  logic   w_ok_rise;
  logic   w_dec_rise;

  // Previous-sample registers come out of reset high, so a button that is
  // already pressed during reset must be released before it counts.
  assign w_ok_rise  = bus.OK_IN & ~r_ok_q;
  assign w_dec_rise = bus.DEC   & ~r_dec_q;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_ok_rise) w_next = S_READY;
      S_READY: if (bus.QUE) w_next = S_GEN;
      S_GEN:   if (bus.QUE_IN) w_next = S_SHOW;
      S_SHOW: begin
        // An external penalty beats a simultaneous answer submission.
        if (bus.WRONG_IN)      w_next = S_MISS;
        else if (w_dec_rise)   w_next = S_JUDGE;
      end
      S_JUDGE: begin
        case (bus.JUDG_IN)
          2'b01:   w_next = S_SHOW;
          2'b10:   w_next = S_MISS;
          2'b11:   w_next = S_CLEAR;
          default: w_next = S_JUDGE;
        endcase
      end
      // One-cycle visit: HP datapath has already applied the penalty here.
      S_MISS:  w_next = (bus.HP_IN == 2'd0) ? S_OVER : S_SHOW;
      S_CLEAR: begin
        if (bus.SEL)         w_next = S_IDLE;
        else if (w_ok_rise)  w_next = S_READY;
      end
      S_OVER:  if (w_ok_rise) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_ok_q  <= 1'b1;
      r_dec_q <= 1'b1;
    end else begin
      r_state <= w_next;
      // Registered alongside the state so it tracks STATE with no lag.
      r_ready <= (w_next == S_READY);
      r_ok_q  <= bus.OK_IN;
      r_dec_q <= bus.DEC;
    end
  end

  assign bus.STATE     = r_state;
  assign bus.READY_OUT = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_control
// Description : Self-checking bench for the quiz game-flow controller.
//               Stimulus steps push the expected state into a scoreboard;
//               a monitor pops and compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control;

  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_bad = 0;

  string      tag_q[$];
  logic [3:0] exp_q[$];

  control_if bus ();

  control u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Queue the state expected after the coming rising edge, then move to
  // the next falling edge where new inputs are applied.
  task automatic step(input string tag, input logic [3:0] exp_state);
    tag_q.push_back(tag);
    exp_q.push_back(exp_state);
    @(negedge CLK);
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      string      t;
      logic [3:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check({t, ".state"}, int'(bus.STATE), int'(e));
      check({t, ".ready"}, int'(bus.READY_OUT), (e == 4'd1) ? 1 : 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b0;
    bus.OK_IN = 0; bus.QUE = 0; bus.QUE_IN = 0; bus.DEC = 0; bus.SEL = 0;
    bus.JUDG_IN = 2'b00; bus.WRONG_IN = 0; bus.HP_IN = 2'd2;

    // Reset and start
    step("reset", 4'd0);
    RST = 1'b1;
    step("idle", 4'd0);
    bus.OK_IN = 1;                         step("start", 4'd1);
    // Question fetch chain
    bus.QUE = 1;                           step("gen", 4'd2);
    bus.QUE_IN = 1;                        step("show", 4'd3);
    bus.QUE = 0; bus.QUE_IN = 0; bus.OK_IN = 0;
    // Correct path, factors remain
    bus.DEC = 1; bus.JUDG_IN = 2'b01;      step("judge1", 4'd4);
    step("j01_back", 4'd3);
    step("dec_held", 4'd3);
    bus.DEC = 0;                           step("dec_low", 4'd3);
    bus.DEC = 1; bus.JUDG_IN = 2'b11;      step("judge2", 4'd4);
    step("j11_clear", 4'd6);
    bus.DEC = 0;                           step("clear_wait", 4'd6);
    bus.OK_IN = 1;                         step("clear_ok", 4'd1);
    // Second round, quit from clear with SEL beating ok_rise
    bus.OK_IN = 0; bus.QUE = 1; bus.QUE_IN = 1; step("gen2", 4'd2);
    step("show2", 4'd3);
    bus.QUE = 0; bus.QUE_IN = 0;
    bus.DEC = 1; bus.JUDG_IN = 2'b11;      step("judge3", 4'd4);
    step("clear2", 4'd6);
    bus.DEC = 0; bus.SEL = 1; bus.OK_IN = 1; step("sel_quit", 4'd0);
    bus.SEL = 0;                           step("ok_held", 4'd0);
    bus.OK_IN = 0;                         step("ok_rel", 4'd0);
    bus.OK_IN = 1;                         step("restart", 4'd1);
    // Miss with HP left, then penalty to game over
    bus.OK_IN = 0; bus.QUE = 1; bus.QUE_IN = 1; step("gen3", 4'd2);
    step("show3", 4'd3);
    bus.QUE = 0; bus.QUE_IN = 0;
    bus.DEC = 1; bus.JUDG_IN = 2'b10; bus.HP_IN = 2'd2; step("judge4", 4'd4);
    step("miss", 4'd5);
    step("miss_back", 4'd3);
    bus.DEC = 0;                           step("show_idle", 4'd3);
    bus.WRONG_IN = 1; bus.DEC = 1; bus.HP_IN = 2'd0; step("wrong_wins", 4'd5);
    bus.WRONG_IN = 0;                      step("over", 4'd7);
    bus.DEC = 0;                           step("over_wait", 4'd7);
    bus.OK_IN = 1;                         step("over_ok", 4'd0);
    bus.OK_IN = 0;                         step("idle2", 4'd0);
    // Reset mid-game from S_JUDGE
    bus.OK_IN = 1; bus.HP_IN = 2'd2;       step("start4", 4'd1);
    bus.OK_IN = 0; bus.QUE = 1; bus.QUE_IN = 1; step("gen4", 4'd2);
    step("show4", 4'd3);
    bus.QUE = 0; bus.QUE_IN = 0;
    bus.DEC = 1; bus.JUDG_IN = 2'b00;      step("judge5", 4'd4);
    step("pending", 4'd4);
    RST = 1'b0; bus.JUDG_IN = 2'b11; bus.OK_IN = 1; step("mid_reset", 4'd0);
    // OK_IN held through and after reset must not start the game
    RST = 1'b1; bus.DEC = 0;               step("ok_thru_rst", 4'd0);
    step("ok_thru_rst2", 4'd0);
    bus.OK_IN = 0;                         step("ok_rel2", 4'd0);
    bus.OK_IN = 1;                         step("ok_rise2", 4'd1);

    @(posedge CLK); #2;
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
